// File: rtl/key_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry controller.
package key_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   function automatic logic key_is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/key_idle_timer.sv
// Inactivity up-counter: clr has priority over en; expire flags the last idle count.
module key_idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: zero on clear, advance while enabled, otherwise hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {CW{1'b0}};
      end else if (en) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {CW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = en && (count_q == LAST);

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: assembles BCD digits, edits them, and hands the
// completed entry to a consumer over valid/ready, with an inactivity timeout.
module key_entry_ctrl
   import key_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_flag,
   input  logic [3:0]                   key_value,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [4*DIGITS-1:0]          out_data,
   output logic [$clog2(DIGITS+1)-1:0]  out_len,
   output logic [4*DIGITS-1:0]          disp_data,
   output logic [$clog2(DIGITS+1)-1:0]  disp_len,
   output logic                         evt_overflow,
   output logic                         evt_timeout,
   output logic                         evt_drop
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned LW = $clog2(DIGITS + 1);

   state_e          state_q, state_d;
   logic [W-1:0]    buf_q, buf_d;
   logic [LW-1:0]   len_q, len_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [LW-1:0]   out_len_q, out_len_d;
   logic            out_valid_q, out_valid_d;
   logic            ovf_q, ovf_d;
   logic            tmo_q, tmo_d;
   logic            drop_q, drop_d;

   logic            key_act_s;
   logic            timer_en_s;
   logic            timer_clr_s;
   logic            expire_s;

   // Codes 0xD..0xF never count as key events anywhere.
   assign key_act_s   = key_flag && (key_value <= KEY_CLEAR);
   assign timer_en_s  = (state_q == ST_ENTRY);
   assign timer_clr_s = (state_q != ST_ENTRY) || key_act_s;

   key_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr_s),
      .en     (timer_en_s),
      .expire (expire_s)
   );

   // Next-state, edit buffer and output-register logic.
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      len_d       = len_q;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      out_valid_d = out_valid_q;
      ovf_d       = 1'b0;
      tmo_d       = 1'b0;
      drop_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_act_s && key_is_digit(key_value)) begin
               buf_d   = W'(key_value);
               len_d   = LW'(1);
               state_d = ST_ENTRY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ENTRY: begin
            // A key beats a simultaneous timer expiry.
            if (key_act_s) begin
               if (key_is_digit(key_value)) begin
                  if (len_q < LW'(DIGITS)) begin
                     buf_d = (buf_q << 3'd4) | W'(key_value);
                     len_d = len_q + LW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (key_value == KEY_BACK) begin
                  buf_d = buf_q >> 3'd4;
                  len_d = len_q - LW'(1);
                  if (len_q == LW'(1)) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_ENTRY;
                  end
               end else if (key_value == KEY_CLEAR) begin
                  buf_d   = {W{1'b0}};
                  len_d   = {LW{1'b0}};
                  state_d = ST_IDLE;
               end else begin
                  out_data_d  = buf_q;
                  out_len_d   = len_q;
                  out_valid_d = 1'b1;
                  state_d     = ST_HOLD;
               end
            end else if (expire_s) begin
               buf_d   = {W{1'b0}};
               len_d   = {LW{1'b0}};
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ENTRY;
            end
         end
         ST_HOLD: begin
            drop_d = key_act_s;
            if (out_ready) begin
               out_valid_d = 1'b0;
               buf_d       = {W{1'b0}};
               len_d       = {LW{1'b0}};
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            buf_d       = {W{1'b0}};
            len_d       = {LW{1'b0}};
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         buf_q       <= {W{1'b0}};
         len_q       <= {LW{1'b0}};
         out_data_q  <= {W{1'b0}};
         out_len_q   <= {LW{1'b0}};
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         tmo_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         len_q       <= len_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         tmo_q       <= tmo_d;
         drop_q      <= drop_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_len      = out_len_q;
   assign disp_data    = buf_q;
   assign disp_len     = len_q;
   assign evt_overflow = ovf_q;
   assign evt_timeout  = tmo_q;
   assign evt_drop     = drop_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: a digit-queue model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_key_entry_ctrl;

   localparam int DIGITS  = 4;
   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_flag = 1'b0;
   logic [3:0]  key_value = 4'h0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [15:0] out_data;
   logic [2:0]  out_len;
   logic [15:0] disp_data;
   logic [2:0]  disp_len;
   logic        evt_overflow, evt_timeout, evt_drop;

   int n_pass = 0;
   int n_total = 0;

   key_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .key_flag(key_flag), .key_value(key_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_len(out_len), .disp_data(disp_data), .disp_len(disp_len),
      .evt_overflow(evt_overflow), .evt_timeout(evt_timeout), .evt_drop(evt_drop)
   );

   always #5 clk = ~clk;

   // Model: the live entry is a queue of digits, oldest first.
   int          dq[$];
   bit          m_hold = 1'b0;
   int          m_idle = 0;
   logic [15:0] m_out_data = 16'h0;
   int          m_out_len = 0;
   bit          m_ovf = 1'b0, m_tmo = 1'b0, m_drop = 1'b0;

   function automatic logic [15:0] qval(input int q[$]);
      logic [15:0] v = 16'h0;
      foreach (q[i]) v = v + 16'(q[i] * (16 ** (q.size() - 1 - i)));
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         dq.delete(); m_hold = 1'b0; m_idle = 0; m_out_data = 16'h0; m_out_len = 0;
         m_ovf = 1'b0; m_tmo = 1'b0; m_drop = 1'b0;
      end else begin
         int k;
         bit act;
         k = int'(key_value);
         act = key_flag && (k <= 12);
         m_ovf = 1'b0; m_tmo = 1'b0; m_drop = 1'b0;
         if (m_hold) begin
            if (act) m_drop = 1'b1;
            if (out_ready) begin m_hold = 1'b0; dq.delete(); end
         end else if (act) begin
            if (k <= 9) begin
               if (dq.size() < DIGITS) dq.push_back(k);
               else if (dq.size() > 0) m_ovf = 1'b1;
            end else if (k == 11) begin
               if (dq.size() > 0) void'(dq.pop_back());
            end else if (k == 12) begin
               dq.delete();
            end else if (dq.size() > 0) begin
               m_out_data = qval(dq); m_out_len = dq.size(); m_hold = 1'b1;
            end
            m_idle = 0;
         end else if (dq.size() > 0) begin
            if (m_idle == TIMEOUT - 1) begin dq.delete(); m_tmo = 1'b1; m_idle = 0; end
            else m_idle++;
         end else begin
            m_idle = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         check("out_valid", 32'(out_valid), 32'(m_hold));
         check("out_data", 32'(out_data), 32'(m_out_data));
         check("out_len", 32'(out_len), 32'(m_out_len));
         check("disp_data", 32'(disp_data), 32'(qval(dq)));
         check("disp_len", 32'(disp_len), 32'(dq.size()));
         check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
         check("evt_timeout", 32'(evt_timeout), 32'(m_tmo));
         check("evt_drop", 32'(evt_drop), 32'(m_drop));
      end
   end

   task automatic press(input logic [3:0] k);
      @(posedge clk); #1;
      key_flag = 1'b1; key_value = k;
      @(posedge clk); #1;
      key_flag = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      bit seen;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_disp_len", 32'(disp_len), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      @(negedge clk); rst = 1'b1;

      // 1,2,3,ENTER with ready high
      press(4'h1); press(4'h2); press(4'h3); press(4'hA);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", 32'(out_data), 32'h0123);
      check("t1_len", 32'(out_len), 32'd3);
      cyc(1);
      check("t1_valid_drop", 32'(out_valid), 32'd0);
      check("t1_idle_len", 32'(disp_len), 32'd0);

      // overflow on fifth digit
      out_ready = 1'b0;
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
      check("t2_ovf", 32'(evt_overflow), 32'd1);
      check("t2_disp", 32'(disp_data), 32'h1234);
      press(4'hA);
      check("t2_data", 32'(out_data), 32'h1234);
      check("t2_len", 32'(out_len), 32'd4);
      out_ready = 1'b1;
      cyc(1);
      check("t2_valid_drop", 32'(out_valid), 32'd0);

      // backspace editing
      press(4'h7); press(4'h8); press(4'hB); press(4'h9); press(4'hA);
      check("t3_data", 32'(out_data), 32'h0079);
      check("t3_len", 32'(out_len), 32'd2);
      cyc(1);
      press(4'h5); press(4'hB);
      check("t3_bs_len", 32'(disp_len), 32'd0);
      press(4'hA);
      check("t3_no_valid", 32'(out_valid), 32'd0);

      // timeout 100 cycles after last key
      press(4'h4); press(4'h6);
      seen = 1'b0;
      for (k = 1; k <= 200 && !seen; k++) begin
         cyc(1);
         if (evt_timeout) seen = 1'b1;
      end
      check("t4_tmo_seen", 32'(seen), 32'd1);
      check("t4_tmo_cycle", 32'(k - 1), 32'd100);
      check("t4_disp", 32'(disp_data), 32'h0);

      // key on the expiry cycle wins
      press(4'h4); press(4'h6);
      repeat (98) @(posedge clk);
      #1;
      press(4'h7);
      check("t4b_len", 32'(disp_len), 32'd3);
      check("t4b_disp", 32'(disp_data), 32'h0467);
      check("t4b_no_tmo", 32'(evt_timeout), 32'd0);
      press(4'hC);

      // HOLD with ready low; keys dropped
      out_ready = 1'b0;
      press(4'h2); press(4'hA);
      for (int i = 0; i < 25; i++) begin
         press(4'h5);
         check("t5_drop", 32'(evt_drop), 32'd1);
         check("t5_valid", 32'(out_valid), 32'd1);
         check("t5_data", 32'(out_data), 32'h0002);
      end
      @(posedge clk); #1;
      out_ready = 1'b1; key_flag = 1'b1; key_value = 4'h5;
      @(posedge clk); #1;
      key_flag = 1'b0;
      check("t5_xfer_valid", 32'(out_valid), 32'd0);
      check("t5_xfer_drop", 32'(evt_drop), 32'd1);
      check("t5_xfer_len", 32'(disp_len), 32'd0);

      // async reset during HOLD
      out_ready = 1'b0;
      press(4'h3); press(4'hA);
      check("t6_hold", 32'(out_valid), 32'd1);
      #2; rst = 1'b0; #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_data", 32'(out_data), 32'd0);
      check("t6_rst_len", 32'(disp_len), 32'd0);
      @(negedge clk); rst = 1'b1;
      out_ready = 1'b1;
      press(4'hD); press(4'hA);
      check("t6_no_valid", 32'(out_valid), 32'd0);
      check("t6_idle_len", 32'(disp_len), 32'd0);
      cyc(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
